memoria_sequencia: RTL

Parametrised sequence memory for the sequence-game datapath: a DEPTH x DATA_WIDTH RAM of one-hot symbols with synchronous read, a user write port for recording moves, and a self-timed fill engine that loads a pseudo-random one-hot sequence from an 8-bit LFSR seed. It replaces fixed-content sequence ROMs, so each round's sequence is chosen at run time. It sits between the game FSM (fill/seed, address) and the comparator/LED drivers (data_out).

---
 rtl/memoria_sequencia_if.sv | 32 +++
 rtl/memoria_sequencia.sv | 128 ++++++++++++
 2 files changed

// File: rtl/memoria_sequencia_if.sv
// Bus between the game FSM and the sequence memory.
//   fill/seed        : start a pseudo-random fill, with its LFSR seed
//   busy/done        : fill engine status (done is a one-cycle pulse)
//   wr_en/addr/data  : user write port for recorded moves
//   onehot_err       : one-cycle pulse for a rejected non-one-hot write
//   address/data_out : synchronous read port
// The master modport is the game FSM side; the slave modport is the memory.
interface memoria_sequencia_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  fill;
  logic [7:0]            seed;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  onehot_err;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output fill, seed, wr_en, wr_addr, wr_data, address,
    input  busy, done, onehot_err, data_out
  );

  modport slave (
    input  fill, seed, wr_en, wr_addr, wr_data, address,
    output busy, done, onehot_err, data_out
  );
endinterface

// File: rtl/memoria_sequencia.sv
// Sequence memory for the sequence game: a DEPTH x DATA_WIDTH RAM of one-hot
// symbols with a registered read port, a user write port that only accepts
// one-hot symbols, and a fill engine that writes every word from an 8-bit LFSR.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (RAM contents are kept)
//   bus   : memoria_sequencia_if slave (fill/seed, busy/done, user write,
//           onehot_err, address/data_out)
module memoria_sequencia #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input logic                clock,
  input logic                reset,
  memoria_sequencia_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SEL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_reg;
  logic [7:0]            lfsr_reg;
  logic [ADDR_WIDTH:0]   index_reg;   // one extra bit so the last-word compare never wraps
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] symbol;
  logic [7:0]            lfsr_next;
  logic [7:0]            seed_fixed;
  logic                  wr_onehot;
  logic                  last_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Decode the low LFSR bits into a one-hot symbol.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_symbol
    assign symbol[gi] = (lfsr_reg[SEL_W-1:0] == SEL_W'(gi));
  end

  assign lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  assign seed_fixed = (bus.seed == 8'h00) ? 8'h01 : bus.seed;  // all-zero LFSR would lock up
  assign wr_onehot  = ($countones(bus.wr_data) == 1);
  assign last_word  = (index_reg == (ADDR_WIDTH+1)'(DEPTH - 1));

  // Single RAM write port: the fill engine owns it while filling; otherwise a
  // valid user write gets it unless a fill starts on the same edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_reg == FILL) begin
      mem_we    = 1'b1;
      mem_waddr = index_reg[ADDR_WIDTH-1:0];
      mem_wdata = symbol;
    end else if (bus.wr_en && !bus.fill && wr_onehot) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read; reads the pre-write contents on a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_reg <= '0;
    end else begin
      data_reg <= mem[bus.address];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= 8'h01;
      index_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.fill) begin
            state_reg <= FILL;
            lfsr_reg  <= seed_fixed;
            index_reg <= '0;
            busy_reg  <= 1'b1;
          end else if (bus.wr_en && !wr_onehot) begin
            err_reg <= 1'b1;
          end
        end
        FILL: begin
          lfsr_reg  <= lfsr_next;
          index_reg <= index_reg + 1'b1;
          if (last_word) begin
            done_reg <= 1'b1;
            // A fill on the completing edge chains straight into a new fill;
            // fill pulses on any earlier edge are ignored.
            if (bus.fill) begin
              lfsr_reg  <= seed_fixed;
              index_reg <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.onehot_err = err_reg;
  assign bus.data_out   = data_reg;
endmodule
